change_dispenser: RTL and testbench

//  Payout end of the vending coin path: accepts the change amount computed by the vending FSM
//  and ejects coins one at a time (10s first, then 5s) through a coin hopper with a sensor ack.

---
 rtl/vm_pkg.sv | 18 +
 rtl/coin_stock_counter.sv | 44 ++++
 rtl/change_dispenser.sv | 169 ++++++++++++++++
 tb/tb_change_dispenser.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// rtl/vm_pkg.sv - coin values, amount width and payout state encoding shared by the vending coin path
package vm_pkg;

  // Amount width shared with vending_machine (0..63 units).
  localparam int AMT_W = 6;

  localparam logic [AMT_W-1:0] COIN5_VAL  = 6'd5;
  localparam logic [AMT_W-1:0] COIN10_VAL = 6'd10;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    EJECT,
    WAIT_ACK,
    FINISH
  } payout_state_t;

endpackage

// File: rtl/coin_stock_counter.sv
// rtl/coin_stock_counter.sv - per-denomination hopper stock with refill, decrement and saturation
//
// Ports:
//   clk, rst  rising-edge clock, synchronous active-high reset (loads INIT_VAL)
//   refill    add REFILL_QTY this cycle
//   dec       one coin left the hopper this cycle
//   count     current stock, saturates at 2**STOCK_W-1
module coin_stock_counter #(
  parameter int STOCK_W    = 4,
  parameter int INIT_VAL   = 8,
  parameter int REFILL_QTY = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               refill,
  input  logic               dec,
  output logic [STOCK_W-1:0] count
);

  localparam int STOCK_MAX = (1 << STOCK_W) - 1;
  // Wide enough to hold STOCK_MAX + REFILL_QTY without overflow before clamping.
  localparam int SUM_W     = STOCK_W + $clog2(REFILL_QTY + 1) + 1;

  logic [SUM_W-1:0] sum;

  // Decrement and refill combine in one step, so a same-cycle pair yields
  // min(old - 1 + REFILL_QTY, STOCK_MAX).
  always_comb begin
    sum = SUM_W'(count);
    if (dec && count != '0) sum = sum - SUM_W'(1);
    if (refill)             sum = sum + SUM_W'(REFILL_QTY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= STOCK_W'(INIT_VAL);
    end else if (sum > SUM_W'(STOCK_MAX)) begin
      count <= STOCK_W'(STOCK_MAX);
    end else begin
      count <= sum[STOCK_W-1:0];
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - pays out change one coin at a time (10s first, then 5s) through a sensed hopper
//
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   change_valid/amount/ready payout request handshake (accepted only in IDLE)
//   coin_sensed               hopper exit sensor pulse, one per dropped coin
//   refill_10, refill_5       add REFILL_QTY coins to the matching stock
//   eject_10, eject_5         one-cycle coin drop commands
//   busy, done                payout in progress / one-cycle completion pulse
//   shortfall, jam_error      unpaid remainder and timeout flag of the last payout
//   stock_10, stock_5         current hopper stock
module change_dispenser
  import vm_pkg::*;
#(
  parameter int STOCK_W      = 4,
  parameter int STOCK10_INIT = 8,
  parameter int STOCK5_INIT  = 8,
  parameter int REFILL_QTY   = 4,
  parameter int ACK_TIMEOUT  = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               change_valid,
  input  logic [AMT_W-1:0]   change_amount,
  output logic               change_ready,
  input  logic               coin_sensed,
  input  logic               refill_10,
  input  logic               refill_5,
  output logic               eject_10,
  output logic               eject_5,
  output logic               busy,
  output logic               done,
  output logic [AMT_W-1:0]   shortfall,
  output logic               jam_error,
  output logic [STOCK_W-1:0] stock_10,
  output logic [STOCK_W-1:0] stock_5
);

  localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

  payout_state_t    state, state_nx;
  logic [AMT_W-1:0] remaining, remaining_nx;
  logic [AMT_W-1:0] shortfall_nx;
  logic             jam_nx;
  logic             pick_10, pick_10_nx;
  logic [TMR_W-1:0] timer, timer_nx;
  logic             dec_10, dec_5;

  coin_stock_counter #(
    .STOCK_W   (STOCK_W),
    .INIT_VAL  (STOCK10_INIT),
    .REFILL_QTY(REFILL_QTY)
  ) u_stock_10 (
    .clk   (clk),
    .rst   (rst),
    .refill(refill_10),
    .dec   (dec_10),
    .count (stock_10)
  );

  coin_stock_counter #(
    .STOCK_W   (STOCK_W),
    .INIT_VAL  (STOCK5_INIT),
    .REFILL_QTY(REFILL_QTY)
  ) u_stock_5 (
    .clk   (clk),
    .rst   (rst),
    .refill(refill_5),
    .dec   (dec_5),
    .count (stock_5)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      shortfall <= '0;
      jam_error <= 1'b0;
      pick_10   <= 1'b0;
      timer     <= '0;
    end else begin
      state     <= state_nx;
      remaining <= remaining_nx;
      shortfall <= shortfall_nx;
      jam_error <= jam_nx;
      pick_10   <= pick_10_nx;
      timer     <= timer_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    remaining_nx = remaining;
    shortfall_nx = shortfall;
    jam_nx       = jam_error;
    pick_10_nx   = pick_10;
    timer_nx     = timer;
    dec_10       = 1'b0;
    dec_5        = 1'b0;
    change_ready = 1'b0;
    busy         = 1'b1;
    eject_10     = 1'b0;
    eject_5      = 1'b0;
    done         = 1'b0;

    case (state)
      IDLE: begin
        change_ready = 1'b1;
        busy         = 1'b0;
        if (change_valid) begin
          remaining_nx = change_amount;
          shortfall_nx = '0;
          jam_nx       = 1'b0;
          state_nx     = SELECT;
        end
      end

      // Greedy choice; whatever cannot be paid becomes the shortfall.
      SELECT: begin
        if (remaining >= COIN10_VAL && stock_10 != '0) begin
          pick_10_nx = 1'b1;
          state_nx   = EJECT;
        end else if (remaining >= COIN5_VAL && stock_5 != '0) begin
          pick_10_nx = 1'b0;
          state_nx   = EJECT;
        end else begin
          shortfall_nx = remaining;
          state_nx     = FINISH;
        end
      end

      EJECT: begin
        eject_10 = pick_10;
        eject_5  = !pick_10;
        timer_nx = '0;
        state_nx = WAIT_ACK;
      end

      // The sensor wins over the timeout on the last allowed cycle. The
      // subtraction is safe because SELECT only picks a coin <= remaining.
      WAIT_ACK: begin
        if (coin_sensed) begin
          if (pick_10) begin
            remaining_nx = remaining - COIN10_VAL;
            dec_10       = 1'b1;
          end else begin
            remaining_nx = remaining - COIN5_VAL;
            dec_5        = 1'b1;
          end
          state_nx = SELECT;
        end else if (timer == TMR_W'(ACK_TIMEOUT - 1)) begin
          jam_nx       = 1'b1;
          shortfall_nx = remaining;
          state_nx     = FINISH;
        end else begin
          timer_nx = timer + TMR_W'(1);
        end
      end

      FINISH: begin
        done     = 1'b1;
        state_nx = IDLE;
      end

      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - self-checking bench for change_dispenser with a greedy payout model
module tb_change_dispenser;

  localparam int STOCK_W      = 4;
  localparam int STOCK10_INIT = 8;
  localparam int STOCK5_INIT  = 8;
  localparam int REFILL_QTY   = 4;
  localparam int ACK_TIMEOUT  = 15;
  localparam int STOCK_MAX    = (1 << STOCK_W) - 1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               change_valid = 1'b0;
  logic [5:0]         change_amount = '0;
  logic               change_ready;
  logic               coin_sensed = 1'b0;
  logic               refill_10 = 1'b0;
  logic               refill_5 = 1'b0;
  logic               eject_10, eject_5, busy, done, jam_error;
  logic [5:0]         shortfall;
  logic [STOCK_W-1:0] stock_10, stock_5;

  change_dispenser #(
    .STOCK_W     (STOCK_W),
    .STOCK10_INIT(STOCK10_INIT),
    .STOCK5_INIT (STOCK5_INIT),
    .REFILL_QTY  (REFILL_QTY),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .change_valid (change_valid),
    .change_amount(change_amount),
    .change_ready (change_ready),
    .coin_sensed  (coin_sensed),
    .refill_10    (refill_10),
    .refill_5     (refill_5),
    .eject_10     (eject_10),
    .eject_5      (eject_5),
    .busy         (busy),
    .done         (done),
    .shortfall    (shortfall),
    .jam_error    (jam_error),
    .stock_10     (stock_10),
    .stock_5      (stock_5)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Model of hopper contents.
  int m10, m5;
  // Model predictions for the current payout.
  int e10, e5, esf, ejam, edone;

  // Observations from the last payout.
  int obs_n10, obs_n5, obs_both, obs_overlap, obs_order_bad, obs_first, obs_done;

  function automatic int sat(input int v);
    return (v > STOCK_MAX) ? STOCK_MAX : v;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Greedy payout rule: all affordable 10s from stock, then 5s; an unacked
  // hopper jams on the first coin and pays nothing.
  task automatic model_payout(input int amt, input int dly, input bit withhold);
    int rem;
    rem  = amt;
    ejam = 0;
    if (withhold) begin
      e10 = (amt >= 10 && m10 > 0) ? 1 : 0;
      e5  = (e10 == 0 && amt >= 5 && m5 > 0) ? 1 : 0;
      ejam = e10 + e5;
      esf  = amt;
      edone = (ejam != 0) ? ACK_TIMEOUT + 3 : 2;
    end else begin
      e10 = imin(rem / 10, m10);
      rem = rem - 10 * e10;
      e5  = imin(rem / 5, m5);
      rem = rem - 5 * e5;
      esf = rem;
      m10 = m10 - e10;
      m5  = m5 - e5;
      // Each coin costs select + eject + dly ack cycles; then select + finish.
      edone = (e10 + e5) * (dly + 2) + 2;
    end
  endtask

  // Drives one request and acts as the hopper; all sampling on negedges.
  task automatic run_payout(input int amt, input int dly, input bit withhold,
                            input bit refill_first_ack, input int spurious_at);
    int  ack_at, acks;
    bit  outstanding;
    ack_at = -1; acks = 0; outstanding = 0;
    obs_n10 = 0; obs_n5 = 0; obs_both = 0; obs_overlap = 0; obs_order_bad = 0;
    obs_first = -1; obs_done = -1;
    for (int i = 0; i < 50 && !change_ready; i++) @(negedge clk);
    change_valid  = 1'b1;
    change_amount = amt[5:0];
    @(negedge clk);
    change_valid = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      coin_sensed  = 1'b0;
      refill_10    = 1'b0;
      change_valid = (c == spurious_at);
      if (c == spurious_at) change_amount = 6'd50;
      if (eject_10 || eject_5) begin
        if (outstanding) obs_overlap++;
        outstanding = 1;
        if (eject_10 && eject_5) obs_both++;
        if (eject_10 && obs_n5 > 0) obs_order_bad++;
        if (eject_10) obs_n10++; else obs_n5++;
        if (obs_first < 0) obs_first = c;
        if (!withhold) ack_at = c + dly;
      end
      if (c == ack_at) begin
        coin_sensed = 1'b1;
        outstanding = 0;
        if (refill_first_ack && acks == 0) refill_10 = 1'b1;
        acks++;
      end
      if (done) begin
        obs_done = c;
        break;
      end
      @(negedge clk);
    end
    coin_sensed  = 1'b0;
    refill_10    = 1'b0;
    change_valid = 1'b0;
  endtask

  task automatic pulse_refill(input bit ten, input bit five);
    refill_10 = ten;
    refill_5  = five;
    @(negedge clk);
    refill_10 = 1'b0;
    refill_5  = 1'b0;
    if (ten)  m10 = sat(m10 + REFILL_QTY);
    if (five) m5  = sat(m5 + REFILL_QTY);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m10 = STOCK10_INIT;
    m5  = STOCK5_INIT;
    vectors++; if (change_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", change_ready); end
    vectors++; if ({busy, done, eject_10, eject_5, jam_error} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b expected 00000", {busy, done, eject_10, eject_5, jam_error}); end
    vectors++; if (shortfall !== 6'd0) begin errors++; $display("FAIL reset_shortfall: got %0d expected 0", shortfall); end
    vectors++; if (int'(stock_10) !== STOCK10_INIT || int'(stock_5) !== STOCK5_INIT) begin errors++; $display("FAIL reset_stock: got %0d/%0d expected %0d/%0d", stock_10, stock_5, STOCK10_INIT, STOCK5_INIT); end
  endtask

  task automatic test_basic();
    model_payout(25, 3, 0);
    run_payout(25, 3, 0, 0, 0);
    vectors++; if (obs_n10 !== 2 || obs_n5 !== 1) begin errors++; $display("FAIL basic_coins: got %0d x10 %0d x5 expected 2 x10 1 x5", obs_n10, obs_n5); end
    vectors++; if (obs_order_bad !== 0) begin errors++; $display("FAIL basic_order: got %0d tens after fives expected 0", obs_order_bad); end
    vectors++; if (obs_first !== 2) begin errors++; $display("FAIL basic_latency: got first eject at %0d expected 2", obs_first); end
    vectors++; if (obs_done !== edone) begin errors++; $display("FAIL basic_done: got %0d expected %0d", obs_done, edone); end
    vectors++; if (shortfall !== 6'd0) begin errors++; $display("FAIL basic_shortfall: got %0d expected 0", shortfall); end
    vectors++; if (int'(stock_10) !== 6 || int'(stock_5) !== 7) begin errors++; $display("FAIL basic_stock: got %0d/%0d expected 6/7", stock_10, stock_5); end
  endtask

  task automatic test_drain();
    model_payout(60, 2, 0);
    run_payout(60, 2, 0, 0, 0);
    vectors++; if (obs_n10 !== 6 || int'(stock_10) !== 0) begin errors++; $display("FAIL drain_tens: got %0d coins stock %0d expected 6 coins stock 0", obs_n10, stock_10); end
    model_payout(20, 1, 0);
    run_payout(20, 1, 0, 0, 0);
    vectors++; if (obs_n10 !== 0 || obs_n5 !== 4) begin errors++; $display("FAIL drain_fives: got %0d x10 %0d x5 expected 0 x10 4 x5", obs_n10, obs_n5); end
    vectors++; if (shortfall !== 6'd0 || int'(stock_5) !== m5) begin errors++; $display("FAIL drain_result: got sf %0d stock5 %0d expected sf 0 stock5 %0d", shortfall, stock_5, m5); end
  endtask

  task automatic test_residue();
    model_payout(7, 2, 0);
    run_payout(7, 2, 0, 0, 0);
    vectors++; if (obs_n5 !== 1 || obs_n10 !== 0) begin errors++; $display("FAIL residue_coins: got %0d x10 %0d x5 expected 0 x10 1 x5", obs_n10, obs_n5); end
    vectors++; if (shortfall !== 6'd2 || obs_done < 0) begin errors++; $display("FAIL residue_shortfall: got %0d done %0d expected 2", shortfall, obs_done); end
    model_payout(0, 1, 0);
    run_payout(0, 1, 0, 0, 0);
    vectors++; if (obs_first !== -1 || obs_done !== 2) begin errors++; $display("FAIL zero_amount: got first eject %0d done %0d expected -1 and 2", obs_first, obs_done); end
  endtask

  task automatic test_jam();
    pulse_refill(1, 0);
    model_payout(10, 1, 1);
    run_payout(10, 1, 1, 0, 0);
    vectors++; if (jam_error !== 1'b1 || shortfall !== 6'd10) begin errors++; $display("FAIL jam_flag: got jam %b sf %0d expected jam 1 sf 10", jam_error, shortfall); end
    vectors++; if (obs_done !== ACK_TIMEOUT + 3 || obs_n10 !== 1) begin errors++; $display("FAIL jam_timing: got done %0d ejects %0d expected done %0d ejects 1", obs_done, obs_n10, ACK_TIMEOUT + 3); end
    vectors++; if (int'(stock_10) !== m10) begin errors++; $display("FAIL jam_stock: got %0d expected %0d", stock_10, m10); end
    @(negedge clk);
    vectors++; if (jam_error !== 1'b1) begin errors++; $display("FAIL jam_sticky: got %b expected 1", jam_error); end
    model_payout(3, 1, 0);
    run_payout(3, 1, 0, 0, 0);
    vectors++; if (jam_error !== 1'b0 || shortfall !== 6'd3) begin errors++; $display("FAIL jam_clear: got jam %b sf %0d expected jam 0 sf 3", jam_error, shortfall); end
  endtask

  task automatic test_busy_refill();
    int busy_cnt;
    model_payout(10, 2, 0);
    run_payout(10, 2, 0, 0, 3);
    busy_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy || eject_10 || eject_5) busy_cnt++;
    end
    vectors++; if (busy_cnt !== 0 || int'(stock_10) !== 3) begin errors++; $display("FAIL busy_ignore: got busy cycles %0d stock10 %0d expected 0 and 3", busy_cnt, stock_10); end
    model_payout(10, 2, 0);
    m10 = sat(m10 + REFILL_QTY);
    run_payout(10, 2, 0, 1, 0);
    vectors++; if (int'(stock_10) !== 6) begin errors++; $display("FAIL refill_with_dec: got %0d expected 6", stock_10); end
    pulse_refill(1, 0);
    pulse_refill(1, 0);
    vectors++; if (int'(stock_10) !== 14) begin errors++; $display("FAIL refill_14: got %0d expected 14", stock_10); end
    pulse_refill(1, 0);
    vectors++; if (int'(stock_10) !== STOCK_MAX) begin errors++; $display("FAIL refill_saturate: got %0d expected %0d", stock_10, STOCK_MAX); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    seen = 0;
    change_valid  = 1'b1;
    change_amount = 6'd10;
    @(negedge clk);
    change_valid = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (eject_10 || eject_5) seen = 1;
      @(negedge clk);
    end
    vectors++; if (!seen || busy !== 1'b1) begin errors++; $display("FAIL rstmid_setup: got seen %0d busy %b expected 1 1", seen, busy); end
    rst = 1'b1;
    @(negedge clk);
    vectors++; if (change_ready !== 1'b1 || {busy, done, eject_10, eject_5, jam_error} !== 5'b0 || shortfall !== 6'd0) begin errors++; $display("FAIL rstmid_outputs: got ready %b flags %b sf %0d expected 1 00000 0", change_ready, {busy, done, eject_10, eject_5, jam_error}, shortfall); end
    vectors++; if (int'(stock_10) !== STOCK10_INIT || int'(stock_5) !== STOCK5_INIT) begin errors++; $display("FAIL rstmid_stock: got %0d/%0d expected %0d/%0d", stock_10, stock_5, STOCK10_INIT, STOCK5_INIT); end
    rst = 1'b0;
    m10 = STOCK10_INIT;
    m5  = STOCK5_INIT;
  endtask

  task automatic test_random();
    int amt, dly;
    bit wh;
    for (int n = 0; n < 25; n++) begin
      for (int k = $urandom_range(0, 2); k > 0; k--) pulse_refill($urandom_range(0, 1), $urandom_range(0, 1));
      amt = $urandom_range(0, 63);
      dly = $urandom_range(1, 6);
      wh  = ($urandom_range(0, 7) == 0);
      model_payout(amt, dly, wh);
      run_payout(amt, dly, wh, 0, 0);
      vectors++; if (obs_n10 !== e10 || obs_n5 !== e5) begin errors++; $display("FAIL rand_coins[%0d] amt %0d: got %0d x10 %0d x5 expected %0d x10 %0d x5", n, amt, obs_n10, obs_n5, e10, e5); end
      vectors++; if (int'(shortfall) !== esf || int'(jam_error) !== ejam) begin errors++; $display("FAIL rand_result[%0d] amt %0d: got sf %0d jam %b expected sf %0d jam %0d", n, amt, shortfall, jam_error, esf, ejam); end
      vectors++; if (obs_done !== edone) begin errors++; $display("FAIL rand_done[%0d] amt %0d: got %0d expected %0d", n, amt, obs_done, edone); end
      vectors++; if (int'(stock_10) !== m10 || int'(stock_5) !== m5) begin errors++; $display("FAIL rand_stock[%0d]: got %0d/%0d expected %0d/%0d", n, stock_10, stock_5, m10, m5); end
      vectors++; if (obs_both !== 0 || obs_overlap !== 0 || obs_order_bad !== 0) begin errors++; $display("FAIL rand_eject_rules[%0d]: got both %0d overlap %0d order %0d expected 0 0 0", n, obs_both, obs_overlap, obs_order_bad); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_drain();
    test_residue();
    test_jam();
    test_busy_refill();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors %0d miscompares", vectors, errors);
    $fatal(1);
  end

endmodule
